// File: rtl/demux1_2_reg.sv
// ============================================================================
// Module   : demux1_2_reg
// Brief    : Registered 1-to-2 demultiplexer, one-entry valid/ready buffer per
//            lane. Optional per-lane accept counters under `DEMUX_CNT_EN`.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux1_2_reg #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] outa,
  output logic             outa_valid,
  input  logic             outa_ready,
  output logic [WIDTH-1:0] outb,
  output logic             outb_valid,
  input  logic             outb_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b
`endif
);

  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;
  logic             r_full_a;
  logic             r_full_b;

  logic w_ready_a;
  logic w_ready_b;
  logic w_in_fire;
  logic w_wr_a;
  logic w_wr_b;
  logic w_drain_a;
  logic w_drain_b;

  // A lane can take a word when empty or when it is being drained this cycle.
  assign w_ready_a = ~r_full_a | outa_ready;
  assign w_ready_b = ~r_full_b | outb_ready;
  assign in_ready  = sel ? w_ready_b : w_ready_a;

  assign w_in_fire = in_valid & in_ready;
  assign w_wr_a    = w_in_fire & ~sel;
  assign w_wr_b    = w_in_fire &  sel;
  assign w_drain_a = r_full_a & outa_ready;
  assign w_drain_b = r_full_b & outb_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_a <= '0;
      r_full_a <= 1'b0;
    end else if (w_wr_a) begin
      r_data_a <= in;
      r_full_a <= 1'b1;
    end else if (w_drain_a) begin
      r_full_a <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_b <= '0;
      r_full_b <= 1'b0;
    end else if (w_wr_b) begin
      r_data_b <= in;
      r_full_b <= 1'b1;
    end else if (w_drain_b) begin
      r_full_b <= 1'b0;
    end
  end

  assign outa       = r_data_a;
  assign outa_valid = r_full_a;
  assign outb       = r_data_b;
  assign outb_valid = r_full_b;

`ifdef DEMUX_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt_a;
  logic [CNT_WIDTH-1:0] r_cnt_b;

  // Counters track accepts only; they wrap naturally at 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_wr_a) r_cnt_a <= r_cnt_a + 1'b1;
      if (w_wr_b) r_cnt_b <= r_cnt_b + 1'b1;
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux1_2_reg.sv
// ============================================================================
// Module   : tb_demux1_2_reg
// Brief    : Randomized and directed bench for demux1_2_reg against a
//            queue-based lane model. Define DEMUX_CNT_EN to cover the counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux1_2_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_d = '0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] outa;
  logic        outa_valid;
  logic        outa_ready = 1'b0;
  logic [31:0] outb;
  logic        outb_valid;
  logic        outb_ready = 1'b0;
`ifdef DEMUX_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  always #5 clk = ~clk;

  demux1_2_reg #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in_d),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .outa       (outa),
    .outa_valid (outa_valid),
    .outa_ready (outa_ready),
    .outb       (outb),
    .outb_valid (outb_valid),
    .outb_ready (outb_ready)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b)
`endif
  );

  // Reference model: each lane is a queue of capacity one; the data output
  // shows the most recently written word even after it drains.
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] last_a;
  logic [31:0] last_b;
  int unsigned m_cnt_a;
  int unsigned m_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_a.delete();
    q_b.delete();
    last_a  = '0;
    last_b  = '0;
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  task automatic check_outputs();
    chk("outa_valid", {63'd0, outa_valid}, {63'd0, q_a.size() != 0});
    chk("outb_valid", {63'd0, outb_valid}, {63'd0, q_b.size() != 0});
    chk("outa", {32'd0, outa}, {32'd0, last_a});
    chk("outb", {32'd0, outb}, {32'd0, last_b});
`ifdef DEMUX_CNT_EN
    chk("cnt_a", {48'd0, cnt_a}, {48'd0, m_cnt_a[15:0]});
    chk("cnt_b", {48'd0, cnt_b}, {48'd0, m_cnt_b[15:0]});
`endif
  endtask

  // One clock cycle: drive, check before the edge, then advance the model.
  task automatic step(input logic [31:0] d, input logic s, input logic v,
                      input logic ra, input logic rb, input logic full_chk,
                      output logic accepted);
    logic exp_rdy;
    in_d = d; sel = s; in_valid = v; outa_ready = ra; outb_ready = rb;
    @(negedge clk);
    exp_rdy = s ? (q_b.size() == 0 || rb) : (q_a.size() == 0 || ra);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (full_chk) check_outputs();
    @(posedge clk);
    if (ra && q_a.size() != 0) void'(q_a.pop_front());
    if (rb && q_b.size() != 0) void'(q_b.pop_front());
    accepted = v && exp_rdy;
    if (accepted) begin
      if (s) begin q_b.push_back(d); last_b = d; m_cnt_b++; end
      else   begin q_a.push_back(d); last_a = d; m_cnt_a++; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] cur_d;
    logic        cur_s;
    logic        cur_v;

    model_reset();
    #2;
    do_reset();
    @(posedge clk); #1;

    // Idle after reset: ready for both selects
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Single routing into lane A, then lane B
    step(32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("route_a_data", {32'd0, outa}, 64'hDEADBEEF);
    chk("route_a_valid", {63'd0, outa_valid}, 64'd1);
    chk("route_a_bvalid", {63'd0, outb_valid}, 64'd0);
    @(posedge clk); #1;
    step(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("route_b_data", {32'd0, outb}, 64'hCAFEF00D);
    @(posedge clk); #1;

    // Backpressure on lane A, release, then lane B drain while A stalls
    step(32'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    chk("bp_blocked", {63'd0, acc}, 64'd0);
    step(32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    chk("bp_release", {63'd0, acc}, 64'd1);
    @(negedge clk);
    chk("bp_new_word", {32'd0, outa}, 64'h1);
    chk("bp_new_valid", {63'd0, outa_valid}, 64'd1);
    @(posedge clk); #1;
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc);

    // Streaming 0..7 into lane B with continuous drain
    for (int i = 0; i < 8; i++) begin
      step(i, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, acc);
      chk("stream_acc", {63'd0, acc}, 64'd1);
    end
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, acc);

    // Asynchronous reset with both lanes full
    step(32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    step(32'h5A5A5A5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", {63'd0, outa_valid}, 64'd0);
    chk("async_rst_b", {63'd0, outb_valid}, 64'd0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    step(32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, acc);

    // Randomized traffic honouring the producer hold rule
    cur_d = $urandom; cur_s = 1'($urandom); cur_v = 1'($urandom);
    for (int i = 0; i < 3000; i++) begin
      step(cur_d, cur_s, cur_v, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0), 1'b1, acc);
      if (!(cur_v && !acc)) begin
        cur_d = $urandom; cur_s = 1'($urandom); cur_v = 1'($urandom_range(0, 3) != 0);
      end
    end

`ifdef DEMUX_CNT_EN
    // Counter wrap: 65535 accepts into lane A, then one more
    do_reset();
    for (int i = 0; i < 65535; i++)
      step(i, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    @(negedge clk);
    chk("cnt_a_max", {48'd0, cnt_a}, 64'hFFFF);
    @(posedge clk); #1;
    step(32'h12345678, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    @(negedge clk);
    chk("cnt_a_wrap", {48'd0, cnt_a}, 64'h0);
    chk("cnt_b_hold", {48'd0, cnt_b}, 64'h0);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/demux1_2_reg.md
# demux1_2_reg

Registered 1-to-2 demultiplexer for 32-bit data words with valid/ready handshaking on every side. It is the steering counterpart of the 2:1 datapath multiplexers in the RISC-V core. A single producer, such as the load/store stage, presents a word plus a select bit. The block routes that word into one of two one-entry output buffers, for example data memory versus the MMIO path. Each output lane drains independently to its own consumer.

## Interface
Parameters:
- `WIDTH`, default 32: data word width.
- `CNT_WIDTH`, default 16: width of the per-lane transfer counters (used only when `DEMUX_CNT_EN` is defined).

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `in` input, WIDTH: data word from the producer.
- `sel` input, 1: destination select; 0 routes to lane A, 1 routes to lane B.
- `in_valid` input, 1: producer has a word on `in`/`sel`.
- `in_ready` output, 1: block accepts the word this cycle.
- `outa` output, WIDTH: lane A buffered data.
- `outa_valid` output, 1: lane A buffer holds a word.
- `outa_ready` input, 1: lane A consumer takes the word.
- `outb` output, WIDTH: lane B buffered data.
- `outb_valid` output, 1: lane B buffer holds a word.
- `outb_ready` input, 1: lane B consumer takes the word.
- `cnt_a` output, CNT_WIDTH: lane A accepted-transfer count (present only with `DEMUX_CNT_EN`).
- `cnt_b` output, CNT_WIDTH: lane B accepted-transfer count (present only with `DEMUX_CNT_EN`).

## Operation
- Each lane has a one-entry buffer: a data register plus a full flag. `outX_valid` equals that lane's full flag, and `outX` is that lane's data register.
- Accept (in_fire) = `in_valid & in_ready`. Drain (X_fire) = `outX_valid & outX_ready`.
- `in_ready` is combinational and depends only on `sel` and the selected lane: `sel ? (!full_b | outb_ready) : (!full_a | outa_ready)`. It never depends on `in_valid`.
- On in_fire, `in` is written into the buffer of the lane chosen by `sel` and that lane's full flag is set. The other lane is untouched.
- On X_fire without a simultaneous write to lane X, full_X is cleared. The data register holds its old value.
- Simultaneous drain and write on the same lane: the buffer is overwritten with the new word and full stays 1. This gives one word per cycle sustained per lane, with no bubble.
- The two lanes are independent. Lane B may drain while lane A is stalled. There is no ordering guarantee across lanes; within a lane, order is strictly FIFO.
- When `in_valid` is 0, the value of `sel` is don't-care. It affects `in_ready` only.
- Producer rule: once `in_valid` is asserted, `in` and `sel` hold stable until in_fire.
- Consumer visibility: `outX`/`outX_valid` hold stable while `outX_valid & !outX_ready`.

## Timing
- Latency: a word accepted at edge N is visible on `outX`/`outX_valid` after edge N, i.e. one cycle.
- Throughput: one word per cycle into each lane, given continuous `outX_ready`.
- Reset (async assert, sync deassert handled upstream): `in_ready` follows the formula with both full flags 0, so it reads 1. `outa`/`outb` = 0, `outa_valid`/`outb_valid` = 0, `cnt_a`/`cnt_b` = 0.
- Reset asserted mid-transfer: buffered words are discarded, valids drop immediately (asynchronously), and no partial state survives.
- A full lane whose `outX_ready` is low blocks only producer words whose `sel` targets that lane.

## Configuration
- `DEMUX_CNT_EN` defined: the `cnt_a`/`cnt_b` ports exist. Each counter increments by 1 on every in_fire into its lane. The counters wrap modulo 2^CNT_WIDTH (0xFFFF → 0x0000 at the default width). They reset to 0. They are not affected by drains.
- `DEMUX_CNT_EN` not defined: the counter ports and logic are absent. Datapath behaviour is identical.

## Test plan
- Reset then idle: after `rst_n` low→high, outa_valid=0, outb_valid=0, outa=0, outb=0, in_ready=1 for both sel values.
- Single routing: in=32'hDEADBEEF, sel=0, in_valid=1 for one cycle, outa_ready=0 → next cycle outa=DEADBEEF, outa_valid=1, outb_valid=0. Then sel=1 with in_valid → in_ready=1 and outb receives the word.
- Backpressure: lane A full, outa_ready=0, in_valid=1, sel=0, in=32'h1 → in_ready=0 and outa holds the old word. Raise outa_ready → same cycle in_ready=1; next cycle outa=1, outa_valid=1.
- Streaming: 8 words 0..7 with sel=1 every cycle and outb_ready=1 throughout → in_ready stays 1 and outb shows 0..7 on consecutive cycles, one cycle delayed.
- Reset mid-operation: both lanes full, pull `rst_n` low without a clock edge → outa_valid/outb_valid drop to 0 immediately; after release, in_ready=1.
- With `DEMUX_CNT_EN`: preload by driving 65535 accepts into lane A, then one more → cnt_a wraps to 0 and cnt_b is unchanged.
